// File: rtl/fifo_rd_packer_if.sv
// Bundle of the FIFO read port and the packed output stream seen by fifo_rd_packer.
// The packer uses the master view and the surrounding environment uses the slave view.
`default_nettype none

interface fifo_rd_packer_if #(
  parameter int DSIZE = 8,
  parameter int PACK  = 4,
  parameter int CNTW  = 16
);
  logic [DSIZE-1:0]      rdata;
  logic                  rempty;
  logic                  rinc;
  logic                  flush;
  logic [DSIZE*PACK-1:0] out_data;
  logic [PACK-1:0]       out_be;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNTW-1:0]       word_count;
  logic                  busy;

  modport master (
    input  rdata, rempty, flush, out_ready,
    output rinc, out_data, out_be, out_valid, word_count, busy
  );

  modport slave (
    output rdata, rempty, flush, out_ready,
    input  rinc, out_data, out_be, out_valid, word_count, busy
  );
endinterface

`default_nettype wire

// File: rtl/fifo_rd_packer.sv
// Pops items from a first-word-fall-through FIFO and packs PACK of them into one
// little-endian word on a valid/ready stream; a flush emits a partial word with lane enables.
`default_nettype none

module fifo_rd_packer #(
  parameter int DSIZE = 8,
  parameter int PACK  = 4,
  parameter int CNTW  = 16
) (
  input  logic              rclk,
  input  logic              rrst,
  fifo_rd_packer_if.master  bus
);
  localparam int CW = $clog2(PACK + 1);
  localparam int WW = DSIZE * PACK;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   acc_cnt, acc_cnt_nx;
  logic [WW-1:0]   acc, acc_nx;
  logic            flush_pend, flush_pend_nx;
  logic [WW-1:0]   out_data_q;
  logic [PACK-1:0] out_be_q, be_nx;
  logic            out_valid_q;
  logic [CNTW-1:0] word_count_q;
  logic            pop, xfer, accept;

  assign accept = out_valid_q & bus.out_ready;

  // Lanes below acc_cnt hold real items.
  always_comb begin
    be_nx = '0;
    for (int k = 0; k < PACK; k++) begin
      be_nx[k] = (CW'(k) < acc_cnt);
    end
  end

  always_comb begin
    pop           = 1'b0;
    xfer          = 1'b0;
    acc_nx        = acc;
    acc_cnt_nx    = acc_cnt;
    flush_pend_nx = flush_pend;
    state_nx      = state;
    pop = !rrst && !bus.rempty && (acc_cnt < CW'(PACK)) && !flush_pend;
    case (state)
      FILL: begin
        if (pop) begin
          acc_nx[acc_cnt*DSIZE +: DSIZE] = bus.rdata;
          acc_cnt_nx = acc_cnt + CW'(1);
        end
        if (bus.flush) flush_pend_nx = 1'b1;
        if ((acc_cnt_nx == CW'(PACK)) || flush_pend_nx) state_nx = DRAIN;
      end
      DRAIN: begin
        // A flush arriving here is absorbed: only one can be pending.
        if ((acc_cnt != '0) && (!out_valid_q || bus.out_ready)) begin
          xfer          = 1'b1;
          acc_nx        = '0;
          acc_cnt_nx    = '0;
          flush_pend_nx = 1'b0;
          state_nx      = FILL;
        end else if (flush_pend && (acc_cnt == '0)) begin
          flush_pend_nx = 1'b0;
          state_nx      = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state        <= FILL;
      acc          <= '0;
      acc_cnt      <= '0;
      flush_pend   <= 1'b0;
      out_data_q   <= '0;
      out_be_q     <= '0;
      out_valid_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      state      <= state_nx;
      acc        <= acc_nx;
      acc_cnt    <= acc_cnt_nx;
      flush_pend <= flush_pend_nx;
      // A new word may load in the same cycle the held one is accepted.
      if (xfer) begin
        out_data_q  <= acc;
        out_be_q    <= be_nx;
        out_valid_q <= 1'b1;
      end else if (accept) begin
        out_valid_q <= 1'b0;
      end
      if (accept) word_count_q <= word_count_q + CNTW'(1);
    end
  end

  assign bus.rinc       = pop;
  assign bus.out_data   = out_data_q;
  assign bus.out_be     = out_be_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.word_count = word_count_q;
  assign bus.busy       = (acc_cnt != '0) | out_valid_q | flush_pend;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
// Directed vector table plus FIFO-model sequences for backpressure and random traffic.
`default_nettype none

module tb_fifo_rd_packer;
  logic rclk = 1'b0;
  logic rrst;
  always #5 rclk = ~rclk;

  fifo_rd_packer_if #(.DSIZE(8), .PACK(4), .CNTW(16)) bus ();

  fifo_rd_packer #(.DSIZE(8), .PACK(4), .CNTW(16)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  typedef struct {
    bit          rst;
    bit          empty;
    logic [7:0]  d;
    bit          fl;
    bit          rdy;
    bit          e_rinc;
    bit          e_valid;
    logic [31:0] e_data;
    logic [3:0]  e_be;
    logic [15:0] e_wc;
    bit          e_busy;
  } vec_t;

  vec_t       vecs[$];
  int         applied = 0;
  int         errors  = 0;
  int         accepts = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  task automatic add(input bit rst, input bit empty, input logic [7:0] d, input bit fl,
                     input bit rdy, input bit e_rinc, input bit e_valid,
                     input logic [31:0] e_data, input logic [3:0] e_be,
                     input logic [15:0] e_wc, input bit e_busy);
    vec_t v;
    v.rst = rst; v.empty = empty; v.d = d; v.fl = fl; v.rdy = rdy;
    v.e_rinc = e_rinc; v.e_valid = e_valid; v.e_data = e_data; v.e_be = e_be;
    v.e_wc = e_wc; v.e_busy = e_busy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rrst = 1'b1; bus.rempty = 1'b1; bus.flush = 1'b0; bus.out_ready = 1'b0; bus.rdata = '0;
    @(posedge rclk); #1;
    rrst = 1'b0;
  endtask

  // One cycle against the FIFO model; accepted words are scored against exp_q.
  task automatic cycle(input bit hold_empty, input bit rdy);
    bit pop_now, acc_now;
    logic [31:0] exp_w;
    bus.rempty    = hold_empty || (fifo_q.size() == 0);
    bus.rdata     = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    bus.out_ready = rdy;
    bus.flush     = 1'b0;
    #1;
    pop_now = bus.rinc;
    acc_now = bus.out_valid & rdy;
    if (acc_now) begin
      accepts++;
      applied++;
      if (exp_q.size() < 4) begin
        errors++;
        $display("FAIL word %0d: out_data=%h be=%h, no expected word left", accepts, bus.out_data, bus.out_be);
      end else begin
        exp_w = {exp_q[3], exp_q[2], exp_q[1], exp_q[0]};
        repeat (4) void'(exp_q.pop_front());
        if (bus.out_data !== exp_w || bus.out_be !== 4'hF) begin
          errors++;
          $display("FAIL word %0d: out_data=%h be=%h, expected %h be f", accepts, bus.out_data, bus.out_be, exp_w);
        end
      end
    end
    @(posedge rclk); #1;
    if (pop_now) void'(fifo_q.pop_front());
  endtask

  initial begin
    rrst = 1'b1; bus.rempty = 1'b1; bus.rdata = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;

    //   rst e  d      fl rdy | rinc val data          be      wc busy
    add(1, 0, 8'h11, 0, 1,   0, 0, 32'h0,        4'h0, 0, 0);
    add(0, 0, 8'h11, 0, 1,   1, 0, 32'h0,        4'h0, 0, 1);
    add(0, 0, 8'h22, 0, 1,   1, 0, 32'h0,        4'h0, 0, 1);
    add(0, 0, 8'h33, 0, 1,   1, 0, 32'h0,        4'h0, 0, 1);
    add(0, 0, 8'h44, 0, 1,   1, 0, 32'h0,        4'h0, 0, 1);
    add(0, 0, 8'h55, 0, 1,   0, 1, 32'h44332211, 4'hF, 0, 1);
    add(0, 0, 8'h55, 0, 1,   1, 0, 32'h44332211, 4'hF, 1, 1);
    add(0, 0, 8'h66, 0, 1,   1, 0, 32'h44332211, 4'hF, 1, 1);
    add(0, 0, 8'h77, 0, 1,   1, 0, 32'h44332211, 4'hF, 1, 1);
    add(0, 0, 8'h88, 0, 1,   1, 0, 32'h44332211, 4'hF, 1, 1);
    add(0, 1, 8'h00, 0, 1,   0, 1, 32'h88776655, 4'hF, 1, 1);
    add(0, 1, 8'h00, 0, 1,   0, 0, 32'h88776655, 4'hF, 2, 0);
    add(0, 0, 8'hAA, 0, 1,   1, 0, 32'h88776655, 4'hF, 2, 1);
    add(0, 0, 8'hBB, 0, 1,   1, 0, 32'h88776655, 4'hF, 2, 1);
    add(0, 0, 8'hCC, 0, 1,   1, 0, 32'h88776655, 4'hF, 2, 1);
    add(0, 1, 8'h00, 1, 1,   0, 0, 32'h88776655, 4'hF, 2, 1);
    add(0, 1, 8'h00, 0, 1,   0, 1, 32'h00CCBBAA, 4'h7, 2, 1);
    add(0, 1, 8'h00, 0, 0,   0, 1, 32'h00CCBBAA, 4'h7, 2, 1);
    add(0, 1, 8'h00, 0, 1,   0, 0, 32'h00CCBBAA, 4'h7, 3, 0);
    add(0, 1, 8'h00, 1, 1,   0, 0, 32'h00CCBBAA, 4'h7, 3, 1);
    add(0, 0, 8'hDD, 0, 1,   0, 0, 32'h00CCBBAA, 4'h7, 3, 0);
    add(0, 0, 8'hDD, 0, 1,   1, 0, 32'h00CCBBAA, 4'h7, 3, 1);
    add(0, 0, 8'hEE, 0, 1,   1, 0, 32'h00CCBBAA, 4'h7, 3, 1);
    add(1, 0, 8'h03, 0, 1,   0, 0, 32'h0,        4'h0, 0, 0);
    add(0, 0, 8'h10, 0, 1,   1, 0, 32'h0,        4'h0, 0, 1);
    add(0, 0, 8'h20, 0, 1,   1, 0, 32'h0,        4'h0, 0, 1);
    add(0, 0, 8'h30, 0, 1,   1, 0, 32'h0,        4'h0, 0, 1);
    add(0, 0, 8'h40, 0, 1,   1, 0, 32'h0,        4'h0, 0, 1);
    add(0, 1, 8'h00, 0, 1,   0, 1, 32'h40302010, 4'hF, 0, 1);
    add(0, 1, 8'h00, 0, 1,   0, 0, 32'h40302010, 4'hF, 1, 0);

    @(posedge rclk); #1;
    foreach (vecs[i]) begin
      bit r;
      rrst = vecs[i].rst; bus.rempty = vecs[i].empty; bus.rdata = vecs[i].d;
      bus.flush = vecs[i].fl; bus.out_ready = vecs[i].rdy;
      #1;
      r = bus.rinc;
      @(posedge rclk); #1;
      applied++;
      if (r !== vecs[i].e_rinc || bus.out_valid !== vecs[i].e_valid ||
          bus.out_data !== vecs[i].e_data || bus.out_be !== vecs[i].e_be ||
          bus.word_count !== vecs[i].e_wc || bus.busy !== vecs[i].e_busy) begin
        errors++;
        $display("FAIL vec %0d: rinc=%b valid=%b data=%h be=%h wc=%0d busy=%b, expected rinc=%b valid=%b data=%h be=%h wc=%0d busy=%b",
                 i, r, bus.out_valid, bus.out_data, bus.out_be, bus.word_count, bus.busy,
                 vecs[i].e_rinc, vecs[i].e_valid, vecs[i].e_data, vecs[i].e_be, vecs[i].e_wc, vecs[i].e_busy);
      end
    end

    // Backpressure: 12 items queued while downstream stalls.
    do_reset();
    fifo_q.delete(); exp_q.delete(); accepts = 0;
    for (int k = 1; k <= 12; k++) begin
      fifo_q.push_back(8'(k * 8'h11));
      exp_q.push_back(8'(k * 8'h11));
    end
    repeat (20) cycle(1'b0, 1'b0);
    check("stall_valid", 32'(bus.out_valid), 32'h1);
    check("stall_data", bus.out_data, 32'h44332211);
    check("stall_rinc", 32'(bus.rinc), 32'h0);
    check("stall_fifo_left", fifo_q.size(), 4);
    for (int c = 0; c < 60 && (exp_q.size() != 0 || bus.busy); c++) cycle(1'b0, 1'b1);
    check("bp_words", accepts, 3);
    check("bp_wc", 32'(bus.word_count), 3);
    check("bp_fifo_drained", fifo_q.size(), 0);

    // Random availability and backpressure over 1024 bytes.
    do_reset();
    fifo_q.delete(); exp_q.delete(); accepts = 0;
    for (int k = 0; k < 1024; k++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      fifo_q.push_back(b);
      exp_q.push_back(b);
    end
    for (int c = 0; c < 20000 && (exp_q.size() != 0 || bus.busy); c++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("rand_left", exp_q.size(), 0);
    check("rand_words", accepts, 256);
    check("rand_wc", 32'(bus.word_count), 256);
    check("rand_busy", 32'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
